prog_loader: RTL
================

Name: prog_loader

Overview:
- Parametrised successor to the UART program-load path; replaces the ad-hoc word counter and DRAM write muxing in the top level.
- Takes bytes from uart_rx, assembles them into WORD_WIDTH words and writes each word to memory at BASE_ADDR+n over a req/ack handshake.
- Optional framed mode adds a length header and a checksum trailer, and reports done and error status for display and debug.

Parameters:
- WORD_WIDTH, 16, word width in bits; must be a multiple of 8.
- ADDR_WIDTH, 25, memory address width.
- BASE_ADDR, 0, address of the first payload word.
- BIG_ENDIAN, 1, 1 = first received byte goes to the MSBs; 0 = first byte goes to the LSBs.
- HEADER_EN, 1, 1 = framed mode (length, payload, checksum); 0 = raw stream mode.
- TIMEOUT_CYCLES, 5000000, number of idle clk cycles allowed mid-word or mid-frame before a timeout error.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, synchronous active-high reset.
- load_en, in, 1, load session enable (level). A rising edge starts a session; a falling edge ends stream mode.
- byte_valid, in, 1, one-cycle strobe that a received byte is present.
- byte_data, in, 8, received byte.
- wr_req, out, 1, memory write request.
- wr_addr, out, ADDR_WIDTH, write address.
- wr_data, out, WORD_WIDTH, write data.
- wr_ack, in, 1, memory write accepted (one-cycle pulse).
- word_count, out, WORD_WIDTH, payload words written so far in this session.
- busy, out, 1, session active.
- done, out, 1, session completed successfully (sticky).
- error, out, 2, sticky error code: 0 none, 1 checksum mismatch, 2 overrun, 3 timeout.

Behaviour:
- Reset: all outputs 0. State IDLE, assembler empty, timeout counter 0.
- Clock enable: load_en is sampled once per clk. A rising edge is detected on the registered value, so it takes effect one cycle after load_en rises.
- Session start (rising edge of load_en, from any state):
  - clear word_count, done, error, the assembler, the checksum and the timer.
  - go to HDR if HEADER_EN=1, otherwise go to DATA.
- Assembler:
  - Counts bytes 0..WORD_WIDTH/8-1 and places each byte according to BIG_ENDIAN.
  - On the last byte the word completes in the same cycle byte_valid is seen, and the count wraps to 0.
  - byte_valid outside a session (IDLE, DONE, ERR) is ignored.
- HDR: the first complete word is latched as len (number of payload words). Next state is DATA, or CSUM if len=0.
- DATA (payload word complete):
  - Load the holding register, assert wr_req the next cycle, and drive wr_addr = BASE_ADDR + word_count, truncated to ADDR_WIDTH (wraps).
  - wr_req, wr_addr and wr_data stay stable until wr_ack is seen.
  - On wr_ack: drop wr_req in the next cycle, increment word_count, and add the word to the checksum (sum mod 2^WORD_WIDTH).
  - The assembler keeps collecting while a request is pending. If another word completes before wr_ack, set error=2 and go to ERR.
  - A complete word arriving in the same cycle as wr_ack is legal; its request follows back-to-back.
  - Framed mode: after the write for word len is acked, go to CSUM.
- CSUM: the next complete word is compared with the checksum.
  - Equal: done=1, go to DONE.
  - Not equal: error=1, go to ERR.
  - Never written to memory.
- Stream mode: on a falling edge of load_en:
  - any partial word is discarded;
  - a pending write still completes (wait for wr_ack);
  - then done=1 and go to DONE.
- Framed mode, load_en falling mid-frame: error=3, ERR.
- Timeout: the timer counts only while busy and not waiting on wr_ack, and restarts on every byte_valid.
  - Stream mode: it runs only when the assembler is partly filled.
  - Reaching TIMEOUT_CYCLES: error=3, ERR, and wr_req is dropped only if it is not pending.
- busy=1 in HDR, DATA, CSUM and in a pending write; 0 in IDLE, DONE and ERR.
- ERR and DONE hold their state until the next session start or rst.
- rst in mid-operation drops wr_req immediately; the partial write is abandoned.
- Priority when events coincide in one cycle: rst > session start > wr_ack > word complete > timeout.

Test Plan:
- Framed, 16-bit, big-endian, BASE_ADDR=0x100. Bytes 00 02 | 12 34 | AB CD | BE 01, with immediate ack. Required: writes 0x1234@0x100 and 0xABCD@0x101, word_count=2, done=1, error=0.
- Same frame with trailer BE 02. Required: both writes happen, error=1, done=0, busy=0.
- Stream mode, little-endian. Bytes 34 12 78 56 9A, then load_en falls. Required: writes 0x1234 and 0x5678, byte 9A discarded, done=1, word_count=2.
- wr_ack held off for 3 words' worth of bytes. Required: error=2 raised on the second word completion, exactly one wr_req outstanding, no extra write.
- Framed session with TIMEOUT_CYCLES=100. Send one byte, then stall for 100 cycles. Required: error=3 in the 100th idle cycle. A new load_en rising edge then clears error and count.
- len=0 with checksum 0000. Required: no wr_req, done=1. Also assert rst during a pending wr_req: wr_req=0 and all outputs 0 the next cycle.

Source files
------------

// File: rtl/prog_loader.sv
// UART program loader: assembles received bytes into words and writes them to memory
// over a req/ack handshake, with optional length header and checksum trailer.
module prog_loader #(
  parameter int unsigned            WORD_WIDTH     = 16,
  parameter int unsigned            ADDR_WIDTH     = 25,
  parameter logic [ADDR_WIDTH-1:0]  BASE_ADDR      = '0,
  parameter bit                     BIG_ENDIAN     = 1'b1,
  parameter bit                     HEADER_EN      = 1'b1,
  parameter int unsigned            TIMEOUT_CYCLES = 5000000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load_en,
  input  logic                  byte_valid,
  input  logic [7:0]            byte_data,
  output logic                  wr_req,
  output logic [ADDR_WIDTH-1:0] wr_addr,
  output logic [WORD_WIDTH-1:0] wr_data,
  input  logic                  wr_ack,
  output logic [WORD_WIDTH-1:0] word_count,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            error
);

  localparam int unsigned NB = WORD_WIDTH / 8;
  localparam int unsigned CW = (NB > 1) ? $clog2(NB) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LAST_BYTE = CW'(NB - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT_CYCLES - 1);

  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_OVERRUN = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_DATA,
    S_CSUM,
    S_FLUSH,
    S_DONE,
    S_ERR
  } state_t;

  state_t r_state, w_state_nx;

  logic                  r_le, r_le_d;
  logic                  w_start, w_fall;
  logic [CW-1:0]         r_byte_cnt;
  logic [WORD_WIDTH-1:0] r_asm, w_asm_nx;
  logic [CW-1:0]         w_pos;
  logic                  w_in_session, w_byte_in, w_word;
  logic [TW-1:0]         r_timer;
  logic                  w_timer_run, w_tmo;
  logic                  w_ack;

  logic                  r_wr_req, w_req_nx;
  logic [ADDR_WIDTH-1:0] r_wr_addr, w_addr_nx;
  logic [WORD_WIDTH-1:0] r_wr_data, w_data_nx;
  logic [WORD_WIDTH-1:0] r_word_count, w_cnt_nx;
  logic [WORD_WIDTH-1:0] r_csum, w_csum_nx;
  logic [WORD_WIDTH-1:0] r_len, w_len_nx;
  logic                  r_done, w_done_nx;
  logic [1:0]            r_error, w_err_nx;

  // load_en edges are taken from the registered copy, so a session starts one cycle late
  always_ff @(posedge clk) begin
    if (rst) begin
      r_le   <= 1'b0;
      r_le_d <= 1'b0;
    end else begin
      r_le   <= load_en;
      r_le_d <= r_le;
    end
  end

  assign w_start = r_le & ~r_le_d;
  assign w_fall  = ~r_le & r_le_d;

  assign w_in_session = (r_state == S_HDR) || (r_state == S_DATA) || (r_state == S_CSUM);
  assign w_byte_in    = byte_valid && w_in_session;
  assign w_word       = w_byte_in && (r_byte_cnt == LAST_BYTE);
  assign w_pos        = BIG_ENDIAN ? (LAST_BYTE - r_byte_cnt) : r_byte_cnt;

  always_comb begin
    w_asm_nx = r_asm;
    for (int unsigned i = 0; i < NB; i++) begin
      if (w_pos == CW'(i)) w_asm_nx[i*8 +: 8] = byte_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_start) begin
      r_byte_cnt <= '0;
      r_asm      <= '0;
    end else if (w_byte_in) begin
      r_asm      <= w_asm_nx;
      r_byte_cnt <= (r_byte_cnt == LAST_BYTE) ? '0 : r_byte_cnt + 1'b1;
    end
  end

  // Stream mode only times out on a partial word; framed mode times out anywhere in the frame
  assign w_timer_run = w_in_session && !r_wr_req && (HEADER_EN || (r_byte_cnt != '0));
  assign w_tmo       = w_timer_run && !w_byte_in && (r_timer == TMO_LAST);

  always_ff @(posedge clk) begin
    if (rst || w_start || w_byte_in) r_timer <= '0;
    else if (w_timer_run)            r_timer <= r_timer + 1'b1;
  end

  assign w_ack = r_wr_req && wr_ack;

  always_comb begin
    w_state_nx = r_state;
    w_req_nx   = r_wr_req;
    w_addr_nx  = r_wr_addr;
    w_data_nx  = r_wr_data;
    w_cnt_nx   = r_word_count;
    w_csum_nx  = r_csum;
    w_len_nx   = r_len;
    w_done_nx  = r_done;
    w_err_nx   = r_error;

    if (w_start) begin
      // A new session abandons any outstanding write, as reset does
      w_state_nx = HEADER_EN ? S_HDR : S_DATA;
      w_req_nx   = 1'b0;
      w_cnt_nx   = '0;
      w_csum_nx  = '0;
      w_len_nx   = '0;
      w_done_nx  = 1'b0;
      w_err_nx   = '0;
    end else begin
      if (w_ack) begin
        w_req_nx  = 1'b0;
        w_cnt_nx  = r_word_count + 1'b1;
        w_csum_nx = r_csum + r_wr_data;
      end

      unique case (r_state)
        S_HDR: begin
          if (w_fall) begin
            w_state_nx = S_ERR;
            w_err_nx   = ERR_TIMEOUT;
          end else if (w_word) begin
            w_len_nx   = w_asm_nx;
            w_state_nx = (w_asm_nx == '0) ? S_CSUM : S_DATA;
          end else if (w_tmo) begin
            w_state_nx = S_ERR;
            w_err_nx   = ERR_TIMEOUT;
          end
        end

        S_DATA: begin
          if (w_fall) begin
            if (HEADER_EN) begin
              w_state_nx = S_ERR;
              w_err_nx   = ERR_TIMEOUT;
            end else if (r_wr_req && !wr_ack) begin
              w_state_nx = S_FLUSH;
            end else begin
              w_state_nx = S_DONE;
              w_done_nx  = 1'b1;
            end
          end else if (HEADER_EN && w_ack && (w_cnt_nx == r_len)) begin
            // Last payload ack; a word completing now is already the trailer
            if (w_word) begin
              if (w_asm_nx == w_csum_nx) begin
                w_state_nx = S_DONE;
                w_done_nx  = 1'b1;
              end else begin
                w_state_nx = S_ERR;
                w_err_nx   = ERR_CSUM;
              end
            end else begin
              w_state_nx = S_CSUM;
            end
          end else if (w_word) begin
            if (r_wr_req && !wr_ack) begin
              w_state_nx = S_ERR;
              w_err_nx   = ERR_OVERRUN;
            end else begin
              w_req_nx  = 1'b1;
              w_data_nx = w_asm_nx;
              w_addr_nx = BASE_ADDR + ADDR_WIDTH'(w_cnt_nx);
            end
          end else if (w_tmo) begin
            w_state_nx = S_ERR;
            w_err_nx   = ERR_TIMEOUT;
          end
        end

        S_CSUM: begin
          if (w_fall) begin
            w_state_nx = S_ERR;
            w_err_nx   = ERR_TIMEOUT;
          end else if (w_word) begin
            if (w_asm_nx == r_csum) begin
              w_state_nx = S_DONE;
              w_done_nx  = 1'b1;
            end else begin
              w_state_nx = S_ERR;
              w_err_nx   = ERR_CSUM;
            end
          end else if (w_tmo) begin
            w_state_nx = S_ERR;
            w_err_nx   = ERR_TIMEOUT;
          end
        end

        S_FLUSH: begin
          if (w_ack) begin
            w_state_nx = S_DONE;
            w_done_nx  = 1'b1;
          end
        end

        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wr_req     <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_word_count <= '0;
      r_csum       <= '0;
      r_len        <= '0;
      r_done       <= 1'b0;
      r_error      <= '0;
    end else begin
      r_state      <= w_state_nx;
      r_wr_req     <= w_req_nx;
      r_wr_addr    <= w_addr_nx;
      r_wr_data    <= w_data_nx;
      r_word_count <= w_cnt_nx;
      r_csum       <= w_csum_nx;
      r_len        <= w_len_nx;
      r_done       <= w_done_nx;
      r_error      <= w_err_nx;
    end
  end

  assign wr_req     = r_wr_req;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign word_count = r_word_count;
  assign done       = r_done;
  assign error      = r_error;
  assign busy       = w_in_session || (r_state == S_FLUSH);

endmodule
